// File: rtl/beep_tone_detect.sv
// beep_tone_detect: measures the period of an asynchronous square wave,
// classifies it against two tone windows and locks onto a tone after
// CONFIRM consecutive matching periods.
//
// Handshake/pulse semantics: period_stb is a single-cycle strobe that is high
// exactly in the cycle period_out holds a freshly measured period; there is no
// back-pressure. tone_change is a single-cycle strobe marking any change of
// tone_id, and tone_valid always equals (tone_id != 0).
module beep_tone_detect #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TONE0_HZ    = 2_000,
  parameter int unsigned TONE1_HZ    = 3_000,
  parameter int unsigned TOL_PCT     = 5,
  parameter int unsigned CONFIRM     = 4,
  parameter int unsigned TIMEOUT_CYC = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic [31:0] period_out,
  output logic        period_stb,
  output logic        tone_valid,
  output logic [1:0]  tone_id,
  output logic        tone_change,
  output logic [1:0]  dbg_state
);

  // Nominal periods and inclusive match windows, integer arithmetic.
  localparam int unsigned P0  = CLK_HZ / TONE0_HZ;
  localparam int unsigned P1  = CLK_HZ / TONE1_HZ;
  localparam int unsigned W0  = P0 * TOL_PCT / 100;
  localparam int unsigned W1  = P1 * TOL_PCT / 100;
  localparam logic [31:0] LO0 = 32'(P0 - W0);
  localparam logic [31:0] HI0 = 32'(P0 + W0);
  localparam logic [31:0] LO1 = 32'(P1 - W1);
  localparam logic [31:0] HI1 = 32'(P1 + W1);
  localparam logic [31:0] TO_C      = 32'(TIMEOUT_CYC);
  localparam logic [3:0]  CONFIRM_C = 4'(CONFIRM);

  // Overlapping windows would make the classification ambiguous.
  if (!((HI1 < LO0) || (HI0 < LO1))) begin : g_window_overlap
    $error("beep_tone_detect: tone match windows overlap");
  end
  if ((CONFIRM < 1) || (CONFIRM > 15)) begin : g_confirm_range
    $error("beep_tone_detect: CONFIRM must be within 1..15");
  end

  typedef enum logic [1:0] {
    S_SILENT = 2'd0,
    S_ARMED  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t      r_state, w_state_nx;
  logic        r_sync1, r_sync2, r_prev;
  logic [31:0] r_count;
  logic [1:0]  r_cand, w_cand_nx;
  logic [3:0]  r_match, w_match_nx;
  logic [31:0] r_period, w_period_nx;
  logic        r_stb, w_stb_nx;
  logic [1:0]  r_id, w_id_nx;
  logic        r_valid;
  logic        r_change, w_change_nx;

  logic        w_rise;
  logic        w_timeout;
  logic [1:0]  w_class;
  logic        w_same;
  logic [3:0]  w_seed;
  logic [3:0]  w_match_calc;
  logic [1:0]  w_cand_calc;

  assign w_rise    = r_sync2 & ~r_prev;
  assign w_timeout = (r_count == TO_C);

  // Two-stage synchroniser for the asynchronous input plus edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= tone_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Period counter: the rise cycle itself is cycle 1 of the next period, so the
  // value seen at the following rise equals the rise-to-rise distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 32'd0;
    end else if (w_rise) begin
      r_count <= 32'd1;
    end else if (r_count < TO_C) begin
      r_count <= r_count + 32'd1;
    end
  end

  // Classify the period that ends at this rise, and the candidate/match update
  // that this period would produce.
  always_comb begin
    w_class = 2'd0;
    if ((r_count >= LO0) && (r_count <= HI0)) begin
      w_class = 2'd1;
    end else if ((r_count >= LO1) && (r_count <= HI1)) begin
      w_class = 2'd2;
    end
    w_same       = (w_class == r_cand) && (w_class != 2'd0);
    w_seed       = (w_class != 2'd0) ? 4'd1 : 4'd0;
    w_match_calc = w_same ? (r_match + 4'd1) : w_seed;
    w_cand_calc  = w_same ? r_cand : w_class;
  end

  // FSM next state and next values of all registered outputs.
  always_comb begin
    w_state_nx  = r_state;
    w_cand_nx   = r_cand;
    w_match_nx  = r_match;
    w_period_nx = r_period;
    w_stb_nx    = 1'b0;
    w_id_nx     = r_id;
    w_change_nx = 1'b0;
    case (r_state)
      S_SILENT: begin
        if (w_rise) begin
          w_state_nx = S_ARMED;
          w_cand_nx  = 2'd0;
          w_match_nx = 4'd0;
        end
      end
      S_ARMED: begin
        if (w_rise) begin
          w_stb_nx    = 1'b1;
          w_period_nx = r_count;
          w_cand_nx   = w_cand_calc;
          w_match_nx  = w_match_calc;
          if ((w_match_calc == CONFIRM_C) && (w_cand_calc != 2'd0)) begin
            w_state_nx  = S_LOCKED;
            w_id_nx     = w_cand_calc;
            w_change_nx = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nx  = S_SILENT;
          w_cand_nx   = 2'd0;
          w_match_nx  = 4'd0;
          w_id_nx     = 2'd0;
          w_change_nx = (r_id != 2'd0);
        end
      end
      S_LOCKED: begin
        if (w_rise) begin
          w_stb_nx    = 1'b1;
          w_period_nx = r_count;
          if (w_class != r_id) begin
            w_state_nx  = S_ARMED;
            w_id_nx     = 2'd0;
            w_change_nx = 1'b1;
            w_cand_nx   = w_class;
            w_match_nx  = w_seed;
          end
        end else if (w_timeout) begin
          w_state_nx  = S_SILENT;
          w_cand_nx   = 2'd0;
          w_match_nx  = 4'd0;
          w_id_nx     = 2'd0;
          w_change_nx = (r_id != 2'd0);
        end
      end
      default: begin
        w_state_nx = S_SILENT;
        w_cand_nx  = 2'd0;
        w_match_nx = 4'd0;
        w_id_nx    = 2'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_SILENT;
      r_cand   <= 2'd0;
      r_match  <= 4'd0;
      r_period <= 32'd0;
      r_stb    <= 1'b0;
      r_id     <= 2'd0;
      r_valid  <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cand   <= w_cand_nx;
      r_match  <= w_match_nx;
      r_period <= w_period_nx;
      r_stb    <= w_stb_nx;
      r_id     <= w_id_nx;
      r_valid  <= (w_id_nx != 2'd0);
      r_change <= w_change_nx;
    end
  end

  assign period_out  = r_period;
  assign period_stb  = r_stb;
  assign tone_valid  = r_valid;
  assign tone_id     = r_id;
  assign tone_change = r_change;
  assign dbg_state   = r_state;

endmodule
